mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_tx.sv | 174 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: a byte FIFO fed through a two-register
// window (TXDATA, STATUS) and drained by an 8N1 serialiser.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] memory_address,
  input  logic [31:0] memory_write,
  input  logic        memory_we,
  output logic [31:0] memory_out,
  output logic        sel,
  output logic        tx
);

  localparam int unsigned PW        = $clog2(FIFO_DEPTH);
  localparam logic [4:0]  DEPTH_L   = 5'(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [15:0]   baud_cnt, baud_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tx_next;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    level;
  logic          full, empty, overflow, busy;
  logic          txdata_wr, status_wr, push, pop, ovf_set, ovf_clr;

  // Address bits below the word offset and the upper store byte are don't-cares.
  logic          unused_bits;
  assign unused_bits = ^{memory_write[31:8], memory_address[1:0]};

  assign sel       = (memory_address[31:3] == BASE_ADDR[31:3]);
  assign txdata_wr = memory_we && sel && !memory_address[2];
  assign status_wr = memory_we && sel &&  memory_address[2];

  assign full  = (level == DEPTH_L);
  assign empty = (level == 5'd0);
  assign busy  = (state != IDLE);

  // A pop in the same cycle frees a slot, so a write at full is still taken.
  assign push    = txdata_wr && (!full || pop);
  assign ovf_set = txdata_wr && full && !pop;
  assign ovf_clr = status_wr && memory_write[3];

  // Register read mux; TXDATA and unselected addresses read as zero.
  always_comb begin
    memory_out = '0;
    if (sel && memory_address[2]) begin
      memory_out = {23'd0, level, overflow, busy, empty, full};
    end
  end

  // FIFO storage; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= memory_write[7:0];
    end
  end

  // FIFO pointers, occupancy count and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: level <= level;
      endcase
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Serialiser next-state, counters, shift register and next line level.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift_reg;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shift_next = fifo_mem[rd_ptr];
          baud_next  = '0;
          bit_next   = '0;
          state_next = START;
        end
      end
      START: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end
      DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next   = bit_idx + 3'd1;
            shift_next = {1'b0, shift_reg[7:1]};
          end
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end
      STOP: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_next  = '0;
          state_next = IDLE;
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
    // Line level follows the state being entered so tx stays registered.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  // Serialiser state register; reset drives the line idle without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_next;
      bit_idx   <= bit_next;
      shift_reg <= shift_next;
      tx        <= tx_next;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed register accesses with a frame scoreboard.
module tb_mmio_uart_tx;

  localparam int unsigned CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] memory_address;
  logic [31:0] memory_write;
  logic        memory_we;
  logic [31:0] memory_out;
  logic        sel;
  logic        tx;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;

  typedef struct {
    logic [7:0] data;
    bit         b2b;
  } exp_t;

  exp_t exp_q[$];

  mmio_uart_tx #(
    .BASE_ADDR   (32'h0000_0100),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .memory_address(memory_address),
    .memory_write  (memory_write),
    .memory_we     (memory_we),
    .memory_out    (memory_out),
    .sel           (sel),
    .tx            (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // One store on the next rising edge; returns 1 time unit after that edge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    memory_address = addr;
    memory_write   = data;
    memory_we      = 1'b1;
    @(posedge clk);
    #1;
    memory_we      = 1'b0;
  endtask

  task automatic rd_status(input string name, input logic [31:0] exp);
    memory_we      = 1'b0;
    memory_address = 32'h0000_0104;
    #1;
    chk(name, memory_out, exp);
  endtask

  task automatic expect_byte(input logic [7:0] d, input bit b2b);
    exp_t e;
    e.data = d;
    e.b2b  = b2b;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s: %0d frames pending after %0d cycles, required 0", name, exp_q.size(), n);
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: captures each 40-cycle frame on tx and checks it against the queue.
  initial begin : monitor
    logic [39:0] samp;
    logic [39:0] ideal;
    logic [7:0]  got;
    int unsigned start_cyc;
    int unsigned last_end;
    bit          have_last;
    bit          aborted;
    exp_t        e;
    have_last = 1'b0;
    last_end  = 0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        start_cyc = cyc;
        samp      = '0;
        samp[0]   = tx;
        aborted   = 1'b0;
        for (int i = 1; i < 40; i++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          samp[i] = tx;
        end
        if (aborted) begin
          have_last = 1'b0;
          continue;
        end
        for (int b = 0; b < 8; b++) got[b] = samp[4 + 4 * b + 2];
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL frame_unexpected: got byte 0x%02h at cycle %0d, required no frame", got, start_cyc);
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < 40; i++) begin
            if (i < 4)       ideal[i] = 1'b0;
            else if (i < 36) ideal[i] = e.data[(i - 4) / 4];
            else             ideal[i] = 1'b1;
          end
          n_cmp++;
          if (samp !== ideal) begin
            n_err++;
            $display("FAIL frame: got waveform 0x%010h (byte 0x%02h), required 0x%010h (byte 0x%02h)",
                     samp, got, ideal, e.data);
          end
          if (e.b2b && have_last) begin
            chk("frame_gap", 32'(start_cyc - last_end), 32'd2);
          end
        end
        last_end  = start_cyc + 39;
        have_last = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n          = 1'b1;
    memory_address = '0;
    memory_write   = '0;
    memory_we      = 1'b0;
    #2;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state; register decode still works while held in reset.
    chk("reset_tx", 32'(tx), 32'd1);
    rd_status("reset_status", 32'h002);
    chk("reset_sel", 32'(sel), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd_status("post_reset_status", 32'h002);

    // Single byte: upper store bits ignored, start bit one edge after the write.
    expect_byte(8'hA5, 1'b0);
    wr(32'h100, 32'h0000_01A5);
    chk("single_tx_before_pop", 32'(tx), 32'd1);
    rd_status("single_status_queued", 32'h010);
    @(posedge clk);
    #1;
    chk("single_tx_start", 32'(tx), 32'd0);
    rd_status("single_status_busy", 32'h006);
    repeat (39) @(posedge clk);
    #1;
    rd_status("single_status_stop_last", 32'h006);
    @(posedge clk);
    #1;
    rd_status("single_status_idle", 32'h002);
    chk("single_tx_idle", 32'(tx), 32'd1);
    drain("single_drain");

    // Two quick writes: first is popped while the second is stored.
    expect_byte(8'h11, 1'b0);
    expect_byte(8'h22, 1'b1);
    wr(32'h100, 32'h11);
    rd_status("two_status_first", 32'h010);
    wr(32'h100, 32'h22);
    rd_status("two_status_second", 32'h014);
    drain("two_drain");
    rd_status("two_status_done", 32'h002);

    // Overflow: six consecutive writes, the sixth is dropped.
    expect_byte(8'h31, 1'b0);
    for (int i = 2; i <= 5; i++) expect_byte(8'(8'h30 + i), 1'b1);
    for (int i = 1; i <= 6; i++) wr(32'h100, 32'(8'h30 + i));
    rd_status("ovf_status_full", 32'h04D);
    wr(32'h104, 32'h7);
    rd_status("ovf_status_noclear", 32'h04D);
    wr(32'h104, 32'h8);
    rd_status("ovf_status_cleared", 32'h045);

    // Full plus pop: a write on the pop cycle is accepted without overflow.
    repeat (34) @(posedge clk);
    #1;
    rd_status("fullpop_status_idle_full", 32'h041);
    expect_byte(8'h37, 1'b1);
    wr(32'h100, 32'h37);
    rd_status("fullpop_status_after", 32'h045);
    drain("fullpop_drain");
    rd_status("fullpop_status_done", 32'h002);

    // Reset mid-frame: line goes high without a clock edge, queue discarded.
    wr(32'h100, 32'hC3);
    wr(32'h100, 32'h5A);
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_tx_data_bit2", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_async", 32'(tx), 32'd1);
    rd_status("midrst_status_in_reset", 32'h002);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expect_byte(8'h96, 1'b0);
    wr(32'h100, 32'h96);
    rd_status("midrst_first_edge_write", 32'h010);
    drain("midrst_drain");
    rd_status("midrst_status_done", 32'h002);

    // Decode: neighbours of the window are not selected and have no effect.
    memory_address = 32'h108;
    #1;
    chk("decode_sel_108", 32'(sel), 32'd0);
    chk("decode_out_108", memory_out, 32'd0);
    memory_address = 32'h0FC;
    #1;
    chk("decode_sel_0fc", 32'(sel), 32'd0);
    chk("decode_out_0fc", memory_out, 32'd0);
    memory_address = 32'h100;
    #1;
    chk("decode_sel_100", 32'(sel), 32'd1);
    chk("decode_txdata_reads_zero", memory_out, 32'd0);
    @(posedge clk);
    #1;
    wr(32'h108, 32'h5A);
    wr(32'h0FC, 32'h5A);
    rd_status("decode_status_no_enqueue", 32'h002);
    repeat (3) @(posedge clk);
    #1;
    chk("decode_tx_idle", 32'(tx), 32'd1);
    repeat (50) @(posedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
